iter_shift_unit: RTL and testbench
==================================

ITER_SHIFT_UNIT -- requirements
Module: iter_shift_unit

Parameters
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; all requirements below are stated for DATA_W = 8.

Interface
REQ-002 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on rising CLK edge.
REQ-004 SHALL have port IN_VALID  input  1  upstream request carries a valid operand set.
REQ-005 SHALL have port IN_READY  output  1  unit can accept an operand set this cycle.
REQ-006 SHALL have port IN_DATA  input  8  operand to shift.
REQ-007 SHALL have port SHIFT  input  8  requested shift amount, unsigned.
REQ-008 SHALL have port SHIFT_OP  input  2  operation: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
REQ-009 SHALL have port OUT_VALID  output  1  OUT holds a completed result.
REQ-010 SHALL have port OUT_READY  input  1  downstream writeback consumes the result.
REQ-011 SHALL have port OUT  output  8  shifted result.
REQ-012 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-014 SHALL drive IN_READY high only in IDLE.
REQ-015 SHALL accept an operand set on a rising edge where IN_READY and IN_VALID are both high, registering IN_DATA into the accumulator and SHIFT_OP into the operation register.
REQ-016 SHALL compute effective count n at accept: ops 00/01/10 use n = min(SHIFT, 8); op 11 uses n = SHIFT[2:0].
REQ-017 SHALL transition IDLE->SHIFT at accept when n != 0, and IDLE->DONE when n = 0 (result equals IN_DATA).
REQ-018 SHALL in SHIFT shift the accumulator by exactly one bit per edge and decrement the count: op 00 fills bit0 with 0, op 01 fills bit7 with 0, op 10 replicates bit7, op 11 moves bit0 into bit7.
REQ-019 SHALL transition SHIFT->DONE on the edge that performs the last (n-th) one-bit step.
REQ-020 SHALL assert OUT_VALID exactly in DONE, first visible n edges after the accept edge (same cycle after accept when n = 0).
REQ-021 SHALL hold OUT and OUT_VALID stable in DONE while OUT_READY is low.
REQ-022 SHALL transition DONE->IDLE on an edge where OUT_READY is high; no new operand is accepted on that same edge.
REQ-023 SHALL ignore IN_DATA, SHIFT, SHIFT_OP and IN_VALID outside the accept edge.
REQ-024 SHALL ignore OUT_READY outside DONE.
REQ-025 SHALL produce 0x00 for ops 00/01 and 0x00 or 0xFF (sign of IN_DATA) for op 10 when SHIFT >= 8, after exactly 8 shift steps.
REQ-026 SHALL keep OUT equal to the accumulator in every state; OUT is defined only while OUT_VALID is high.

Reset
REQ-027 SHALL on an edge with RESET high force state IDLE, accumulator/OUT 0x00, count 0, OUT_VALID 0, BUSY 0, IN_READY 1 on the following cycle.
REQ-028 SHALL give RESET priority over any accept, shift step or output handshake on the same edge; an operation in progress is discarded with no OUT_VALID pulse.
REQ-029 SHALL not use any asynchronous path from RESET to state or outputs.

Verification
REQ-030 SHALL be verified: IN_DATA 0x81, SHIFT 1, op 00 -> OUT 0x02, OUT_VALID visible 1 edge after accept.
REQ-031 SHALL be verified: IN_DATA 0x90, SHIFT 2, op 10 -> OUT 0xE4 after 2 shift edges.
REQ-032 SHALL be verified: IN_DATA 0x81, SHIFT 9, op 11 -> n = 1, OUT 0xC0.
REQ-033 SHALL be verified: IN_DATA 0xFF, SHIFT 20, op 01 -> OUT 0x00 after exactly 8 shift edges; SHIFT 0 any op -> OUT = IN_DATA, OUT_VALID right after accept.
REQ-034 SHALL be verified: OUT_READY held low 5 cycles in DONE -> OUT/OUT_VALID stable, IN_READY low; OUT_READY high -> IDLE next edge, IN_READY high.
REQ-035 SHALL be verified: RESET high during third shift step of SHIFT 6 -> IDLE, OUT 0x00, OUT_VALID never asserted, next accept completes normally.

Source files
------------

// File: rtl/iter_shift_unit.sv
// -----------------------------------------------------------------------------
// iter_shift_unit
//
// Iterative barrel-shifter replacement: a single one-bit shifter stepped once
// per clock. An accepted operand is loaded into the accumulator, shifted
// n times (n derived from SHIFT and SHIFT_OP at accept), then held in DONE
// until the downstream consumer takes it with OUT_READY.
//
// Operations (SHIFT_OP):
//   00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right
//
// Effective count n:
//   ops 00/01/10 : min(SHIFT, DATA_W)   -- saturates, so large shifts give
//                                          all-zero or all-sign results
//   op  11       : SHIFT mod DATA_W     -- rotating by DATA_W is the identity
//
// Handshake:
//   IN_READY  is high only in IDLE; an accept happens on an edge with
//             IN_READY && IN_VALID.
//   OUT_VALID is high only in DONE; DONE -> IDLE on an edge with OUT_READY.
//   BUSY      is high in SHIFT and DONE.
//
// RESET is synchronous and active-high and wins over every other event on
// the same edge; an operation in flight is dropped without a result.
//
// DATA_W is expected to be a power of two (rotate count uses the low bits
// of SHIFT).
// -----------------------------------------------------------------------------
module iter_shift_unit #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [DATA_W-1:0] SHIFT,
    input  logic [1:0]        SHIFT_OP,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT,
    output logic              BUSY
);

    // Count must be able to hold DATA_W itself (saturated shifts).
    localparam int CNT_W = $clog2(DATA_W + 1);
    // Number of SHIFT bits that matter for a rotate.
    localparam int ROT_W = $clog2(DATA_W);

    localparam logic [DATA_W-1:0] SHIFT_SAT = DATA_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t            state;
    shift_op_t         op;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  count;

    logic [CNT_W-1:0]  eff_cnt;
    logic [DATA_W-1:0] step_acc;

    // Effective shift count for the operand set presented this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        eff_cnt = '0;
        if (shift_op_t'(SHIFT_OP) == OP_ROR) begin
            eff_cnt = CNT_W'(SHIFT[ROT_W-1:0]);
        end else if (SHIFT >= SHIFT_SAT) begin
            eff_cnt = CNT_SAT;
        end else begin
            eff_cnt = CNT_W'(SHIFT);
        end
    end

    // One-bit step of the accumulator for the registered operation.
    always_comb begin
        step_acc = acc;
        case (op)
            OP_SLL:  step_acc = {acc[DATA_W-2:0], 1'b0};
            OP_SRL:  step_acc = {1'b0, acc[DATA_W-1:1]};
            OP_SRA:  step_acc = {acc[DATA_W-1], acc[DATA_W-1:1]};
            OP_ROR:  step_acc = {acc[0], acc[DATA_W-1:1]};
            default: step_acc = acc;
        endcase
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (RESET) begin
            state     <= ST_IDLE;
            op        <= OP_SLL;
            acc       <= '0;
            count     <= '0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            IN_READY  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        acc      <= IN_DATA;
                        op       <= shift_op_t'(SHIFT_OP);
                        count    <= eff_cnt;
                        BUSY     <= 1'b1;
                        IN_READY <= 1'b0;
                        if (eff_cnt == '0) begin
                            state     <= ST_DONE;
                            OUT_VALID <= 1'b1;
                        end else begin
                            state     <= ST_SHIFT;
                            OUT_VALID <= 1'b0;
                        end
                    end
                end

                ST_SHIFT: begin
                    acc   <= step_acc;
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state     <= ST_DONE;
                        OUT_VALID <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // Result is held until consumed; no accept on this edge.
                    if (OUT_READY) begin
                        state     <= ST_IDLE;
                        OUT_VALID <= 1'b0;
                        BUSY      <= 1'b0;
                        IN_READY  <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    OUT_VALID <= 1'b0;
                    BUSY      <= 1'b0;
                    IN_READY  <= 1'b1;
                end
            endcase
        end
    end

    // The accumulator is the result in every state.
    assign OUT = acc;

endmodule

// File: tb/tb_iter_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_iter_shift_unit
//
// Self-checking bench for iter_shift_unit (DATA_W = 8). A behavioural model
// computes each result arithmetically at accept time and tracks when it must
// become visible; a compare process checks the DUT against it on every
// falling edge. Directed cases pin literal values; random transactions
// exercise all ops, shift ranges and back-pressure.
// -----------------------------------------------------------------------------
module tb_iter_shift_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN_DATA;
    logic [7:0] SHIFT;
    logic [1:0] SHIFT_OP;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUT;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;

    iter_shift_unit #(.DATA_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .SHIFT     (SHIFT),
        .SHIFT_OP  (SHIFT_OP),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (OUT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int ref_n(input logic [7:0] s, input logic [1:0] op);
        if (op == 2'b11) return int'(s) % 8;
        return (int'(s) > 8) ? 8 : int'(s);
    endfunction

    function automatic logic [7:0] ref_res(input logic [7:0] d, input logic [7:0] s,
                                           input logic [1:0] op);
        int                 n;
        logic [15:0]        t;
        logic signed [7:0]  sd;
        n  = ref_n(s, op);
        sd = d;
        case (op)
            2'b00:   begin t = {8'h00, d} << n; return t[7:0]; end
            2'b01:   return d >> n;
            2'b10:   return sd >>> n;
            default: begin t = {d, d} >> n; return t[7:0]; end
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // m_busy : an operand set is owned by the unit
    // m_left : edges still to go before the result becomes visible
    // m_valid: result visible
    bit         m_init  = 1'b0;
    bit         m_busy  = 1'b0;
    bit         m_valid = 1'b0;
    int         m_left  = 0;
    logic [7:0] m_res   = 8'h00;

    always @(posedge CLK) begin
        if (RESET) begin
            m_init  = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_left  = 0;
        end else if (!m_busy) begin
            if (IN_VALID) begin
                m_busy  = 1'b1;
                m_res   = ref_res(IN_DATA, SHIFT, SHIFT_OP);
                m_left  = ref_n(SHIFT, SHIFT_OP);
                m_valid = (m_left == 0);
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (OUT_READY) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge CLK) begin
        if (m_init) begin
            check("cyc_out_valid", 32'(OUT_VALID), 32'(m_valid));
            check("cyc_busy",      32'(BUSY),      32'(m_busy));
            check("cyc_in_ready",  32'(IN_READY),  32'(!m_busy));
            if (m_valid) check("cyc_out", 32'(OUT), 32'(m_res));
        end
    end

    // ---------------- drivers ----------------
    task automatic tick;
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_ready;
        int guard = 0;
        while (!IN_READY && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_timeout", 32'(guard < 50), 32'd1);
    endtask

    // One complete transaction; returns the held result and the number of
    // edges after accept before OUT_VALID was seen.
    task automatic txn(input logic [7:0] d, input logic [7:0] s, input logic [1:0] op,
                       input int hold, output logic [7:0] got, output int lat);
        wait_ready();
        IN_VALID = 1'b1;
        IN_DATA  = d;
        SHIFT    = s;
        SHIFT_OP = op;
        tick();                         // accept edge has passed
        lat = 0;
        while (!OUT_VALID && lat < 40) begin
            IN_VALID  = 1'($urandom);   // ignored while busy
            IN_DATA   = 8'($urandom);
            SHIFT     = 8'($urandom);
            SHIFT_OP  = 2'($urandom);
            OUT_READY = 1'($urandom);   // ignored outside DONE
            tick();
            lat++;
        end
        check("out_valid_timeout", 32'(lat < 40), 32'd1);
        got = OUT;
        OUT_READY = 1'b0;
        for (int i = 0; i < hold; i++) begin
            IN_VALID = 1'($urandom);
            tick();
            check("hold_out",       32'(OUT),       32'(got));
            check("hold_out_valid", 32'(OUT_VALID), 32'd1);
            check("hold_in_ready",  32'(IN_READY),  32'd0);
        end
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;               // must not be taken on the release edge
        tick();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
        check("release_in_ready",  32'(IN_READY),  32'd1);
        check("release_out_valid", 32'(OUT_VALID), 32'd0);
    endtask

    task automatic directed(input string name, input logic [7:0] d, input logic [7:0] s,
                            input logic [1:0] op, input logic [7:0] exp, input int exp_lat,
                            input int hold);
        logic [7:0] got;
        int         lat;
        check({name, "_model"}, 32'(ref_res(d, s, op)), 32'(exp));
        txn(d, s, op, hold, got, lat);
        check({name, "_out"}, 32'(got), 32'(exp));
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d, s, got;
        logic [1:0] op;
        int         lat;

        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        IN_DATA   = 8'h00;
        SHIFT     = 8'h00;
        SHIFT_OP  = 2'b00;
        OUT_READY = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;

        check("rst_out",       32'(OUT),       32'h00);
        check("rst_in_ready",  32'(IN_READY),  32'd1);
        check("rst_busy",      32'(BUSY),      32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);

        directed("sll_81_1",   8'h81, 8'd1,   2'b00, 8'h02, 1, 0);
        directed("sra_90_2",   8'h90, 8'd2,   2'b10, 8'hE4, 2, 0);
        directed("ror_81_9",   8'h81, 8'd9,   2'b11, 8'hC0, 1, 0);
        directed("srl_ff_20",  8'hFF, 8'd20,  2'b01, 8'h00, 8, 0);
        directed("sll_ff_8",   8'hFF, 8'd8,   2'b00, 8'h00, 8, 0);
        directed("sra_80_200", 8'h80, 8'd200, 2'b10, 8'hFF, 8, 0);
        directed("sra_7f_255", 8'h7F, 8'd255, 2'b10, 8'h00, 8, 0);
        directed("ror_a5_8",   8'hA5, 8'd8,   2'b11, 8'hA5, 0, 0);
        for (int k = 0; k < 4; k++) begin
            directed("zero_shift", 8'hA5, 8'd0, 2'(k), 8'hA5, 0, 0);
        end
        directed("hold_sll_3c_3", 8'h3C, 8'd3, 2'b00, 8'hE0, 3, 5);

        // Reset during the third shift step of a 6-step operation.
        wait_ready();
        IN_VALID = 1'b1;
        IN_DATA  = 8'h5A;
        SHIFT    = 8'd6;
        SHIFT_OP = 2'b01;
        tick();                         // accept
        IN_VALID = 1'b0;
        tick();                         // step 1
        tick();                         // step 2
        RESET = 1'b1;
        tick();                         // step 3 edge: reset wins
        RESET = 1'b0;
        check("midrst_out",       32'(OUT),       32'h00);
        check("midrst_in_ready",  32'(IN_READY),  32'd1);
        check("midrst_busy",      32'(BUSY),      32'd0);
        check("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        repeat (6) tick();              // compare process watches for a stray pulse
        directed("after_rst", 8'h5A, 8'd6, 2'b01, 8'h01, 6, 1);

        // Randomized transactions.
        for (int t = 0; t < 200; t++) begin
            d  = 8'($urandom);
            op = 2'($urandom);
            s  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            txn(d, s, op, int'($urandom_range(0, 3)), got, lat);
            check("rnd_out", 32'(got), 32'(ref_res(d, s, op)));
            check("rnd_lat", 32'(lat), 32'(ref_n(s, op)));
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
